// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one req/gnt/rvalid memory port between the I-cache (port 0)
// and D-cache (port 1); one transaction in flight, with a watchdog that forces an error response.
module mem_port_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int TIMEOUT       = 256
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_wdata_i,
   input  logic        p0_we_i,
   input  logic [3:0]  p0_be_i,
   input  logic        p0_req_i,
   output logic        p0_gnt_o,
   output logic        p0_rvalid_o,
   output logic [31:0] p0_rdata_o,
   output logic        p0_error_o,

   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_wdata_i,
   input  logic        p1_we_i,
   input  logic [3:0]  p1_be_i,
   input  logic        p1_req_i,
   output logic        p1_gnt_o,
   output logic        p1_rvalid_o,
   output logic [31:0] p1_rdata_o,
   output logic        p1_error_o,

   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic        mem_req_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic        mem_error_i
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t          state;
   logic            owner;
   logic            last_owner;
   logic [31:0]     cap_addr;
   logic [31:0]     cap_wdata;
   logic            cap_we;
   logic [3:0]      cap_be;
   logic [WD_W-1:0] wd;

   logic            winner;
   logic            timeout_hit;
   logic            gnt_fire;
   logic            resp_fire;
   logic [31:0]     resp_data;
   logic            resp_err;

   // last_owner resets to 1 so port 0 wins the first contention in round-robin mode
   always_comb begin
      winner = 1'b0;
      if (p0_req_i && p1_req_i) begin
         winner = (PRIORITY_MODE == 1) ? 1'b0 : ~last_owner;
      end else if (p1_req_i) begin
         winner = 1'b1;
      end
   end

   always_comb begin
      timeout_hit = (TIMEOUT != 0) && (state == S_WAIT) && !mem_rvalid_i && (wd == WD_LAST);
      gnt_fire    = (state == S_REQ) && mem_gnt_i;
      resp_fire   = (state == S_WAIT) && (mem_rvalid_i || timeout_hit);
      resp_data   = mem_rvalid_i ? mem_rdata_i : '0;
      resp_err    = mem_rvalid_i ? mem_error_i : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         cap_we     <= 1'b0;
         cap_be     <= '0;
         wd         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (p0_req_i || p1_req_i) begin
                  owner     <= winner;
                  cap_addr  <= winner ? p1_addr_i  : p0_addr_i;
                  cap_wdata <= winner ? p1_wdata_i : p0_wdata_i;
                  cap_we    <= winner ? p1_we_i    : p0_we_i;
                  cap_be    <= winner ? p1_be_i    : p0_be_i;
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_gnt_i) begin
                  last_owner <= owner;
                  wd         <= '0;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rvalid_i || timeout_hit) begin
                  state <= S_IDLE;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req_o   = (state == S_REQ);
      mem_addr_o  = cap_addr;
      mem_wdata_o = cap_wdata;
      mem_we_o    = cap_we;
      mem_be_o    = cap_be;
   end

   always_comb begin
      p0_gnt_o    = gnt_fire && !owner;
      p1_gnt_o    = gnt_fire && owner;
      p0_rvalid_o = resp_fire && !owner;
      p1_rvalid_o = resp_fire && owner;
      p0_rdata_o  = (resp_fire && !owner) ? resp_data : '0;
      p1_rdata_o  = (resp_fire && owner) ? resp_data : '0;
      p0_error_o  = resp_fire && !owner && resp_err;
      p1_error_o  = resp_fire && owner && resp_err;
   end

endmodule
